btb_set_assoc: RTL

Parametrised set-associative branch target buffer for the fetch unit; successor to the fixed 1024-entry direct-mapped BTB. Holds partial tags and compressed targets in WAY_NUM ways, does a one-cycle registered lookup, and takes updates from branch resolution. Victims are chosen per set, round-robin, preferring invalid ways. A sweep FSM clears the valid bits after reset or flush.

---
 rtl/btb_set_assoc_pkg.sv | 29 ++
 rtl/btb_set_assoc_victim.sv | 19 +
 rtl/btb_set_assoc.sv | 128 ++++++++++++
 3 files changed

// File: rtl/btb_set_assoc_pkg.sv
// btb_set_assoc_pkg: FetchUnitTypes package with BTB defaults, entry layout and PC field helpers
package FetchUnitTypes;
  localparam int DEF_ENTRY_NUM = 1024;
  localparam int DEF_WAY_NUM = 2;
  localparam int DEF_TAG_WIDTH = 4;
  localparam int DEF_CONTENT_WIDTH = 13;
  typedef struct packed {
    logic                         valid;
    logic [DEF_TAG_WIDTH-1:0]     tag;
    logic [DEF_CONTENT_WIDTH-1:0] content;
  } BTBWayEntry;
  typedef enum logic {INIT, READY} btb_state_t;
  typedef logic [63:0] raw_t;
  function automatic raw_t field(raw_t v, int lsb, int w);
    return (v >> lsb) & ((raw_t'(1) << w) - raw_t'(1));
  endfunction
  function automatic raw_t get_index(raw_t pc, int idx_w);
    return field(pc, 2, idx_w);
  endfunction
  function automatic raw_t get_tag(raw_t pc, int idx_w, int tag_w);
    return field(pc, idx_w + 2, tag_w);
  endfunction
  function automatic raw_t get_content(raw_t target, int cw);
    return field(target, 2, cw);
  endfunction
  function automatic raw_t make_target(raw_t pc, raw_t content, int cw);
    return ((pc >> (cw + 2)) << (cw + 2)) | (content << 2);
  endfunction
endpackage

// File: rtl/btb_set_assoc_victim.sv
// btb_victim_select: picks the lowest invalid way, else the set's round-robin pointer
module btb_victim_select
  import FetchUnitTypes::*;
#(
  parameter int WAY_NUM = DEF_WAY_NUM,
  parameter int PW = 1
) (
  input  logic [WAY_NUM-1:0] valid,
  input  logic [PW-1:0]      ptr,
  output logic [PW-1:0]      way,
  output logic               full
);
  always_comb begin
    way = ptr;
    for (int w = WAY_NUM - 1; w >= 0; w--)
      if (!valid[w]) way = PW'(w);
  end
  assign full = &valid;
endmodule

// File: rtl/btb_set_assoc.sv
// btb_set_assoc: set-associative BTB with sweep-clear FSM; BTB_UPDATE_BYPASS_EN forwards same-cycle updates to lookups
module btb_set_assoc
  import FetchUnitTypes::*;
#(
  parameter int ENTRY_NUM = DEF_ENTRY_NUM,
  parameter int WAY_NUM = DEF_WAY_NUM,
  parameter int TAG_WIDTH = DEF_TAG_WIDTH,
  parameter int CONTENT_WIDTH = DEF_CONTENT_WIDTH,
  parameter int PC_WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  output logic                ready,
  input  logic                lookupValid,
  input  logic [PC_WIDTH-1:0] lookupPC,
  output logic                respValid,
  output logic                respHit,
  output logic [PC_WIDTH-1:0] respTarget,
  input  logic                updateValid,
  input  logic [PC_WIDTH-1:0] updatePC,
  input  logic [PC_WIDTH-1:0] updateTarget
);
  localparam int SETS = ENTRY_NUM / WAY_NUM;
  localparam int IDX_W = $clog2(SETS);
  localparam int PW = WAY_NUM > 1 ? $clog2(WAY_NUM) : 1;
  typedef struct packed {
    logic                     valid;
    logic [TAG_WIDTH-1:0]     tag;
    logic [CONTENT_WIDTH-1:0] content;
  } entry_t;
  btb_state_t state;
  logic [IDX_W-1:0] cnt;
  entry_t mem [WAY_NUM][SETS];
  logic [PW-1:0] ptr [SETS];
  logic [IDX_W-1:0] lidx, uidx, widx;
  logic [TAG_WIDTH-1:0] ltag, utag;
  logic [CONTENT_WIDTH-1:0] ucont, lcont;
  logic upd_en, uany, ufull, lhit, lgo;
  logic [WAY_NUM-1:0] uvalid, uhit, we;
  logic [PW-1:0] uhit_way, vway, uway;
  entry_t wdata;
  entry_t rd [WAY_NUM];
  assign lidx = IDX_W'(get_index(raw_t'(lookupPC), IDX_W));
  assign ltag = TAG_WIDTH'(get_tag(raw_t'(lookupPC), IDX_W, TAG_WIDTH));
  assign uidx = IDX_W'(get_index(raw_t'(updatePC), IDX_W));
  assign utag = TAG_WIDTH'(get_tag(raw_t'(updatePC), IDX_W, TAG_WIDTH));
  assign ucont = CONTENT_WIDTH'(get_content(raw_t'(updateTarget), CONTENT_WIDTH));
  assign upd_en = updateValid && state == READY && !flush;
  assign lgo = lookupValid && state == READY && lhit;
  always_comb begin
    uvalid = '0;
    uhit = '0;
    uhit_way = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--) begin
      uvalid[w] = mem[w][uidx].valid;
      uhit[w] = mem[w][uidx].valid && mem[w][uidx].tag == utag;
      if (uhit[w]) uhit_way = PW'(w);
    end
  end
  assign uany = |uhit;
  btb_victim_select #(.WAY_NUM(WAY_NUM), .PW(PW)) u_victim (
    .valid(uvalid),
    .ptr  (ptr[uidx]),
    .way  (vway),
    .full (ufull)
  );
  assign uway = uany ? uhit_way : vway;
  assign widx = state == INIT ? cnt : uidx;
  assign wdata = state == INIT ? '0 : {1'b1, utag, ucont};
  always_comb begin
    we = '0;
    for (int w = 0; w < WAY_NUM; w++)
      we[w] = state == INIT || (upd_en && uway == PW'(w));
  end
  always_ff @(posedge clk)
    for (int w = 0; w < WAY_NUM; w++)
      if (we[w]) mem[w][widx] <= wdata;
  // The pointer advances only on a true eviction: no hit and no free way.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int s = 0; s < SETS; s++) ptr[s] <= '0;
    else if (upd_en && !uany && ufull)
      ptr[uidx] <= ptr[uidx] == PW'(WAY_NUM - 1) ? '0 : ptr[uidx] + PW'(1);
  always_comb begin
    for (int w = 0; w < WAY_NUM; w++) begin
      rd[w] = mem[w][lidx];
`ifdef BTB_UPDATE_BYPASS_EN
      if (upd_en && we[w] && uidx == lidx) rd[w] = wdata;
`endif
    end
  end
  always_comb begin
    lhit = 1'b0;
    lcont = '0;
    for (int w = WAY_NUM - 1; w >= 0; w--)
      if (rd[w].valid && rd[w].tag == ltag) begin
        lhit = 1'b1;
        lcont = rd[w].content;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= INIT;
      cnt <= '0;
      ready <= 1'b0;
    end else if (flush) begin
      state <= INIT;
      cnt <= '0;
      ready <= 1'b0;
    end else if (state == INIT) begin
      cnt <= cnt + IDX_W'(1);
      if (cnt == IDX_W'(SETS - 1)) begin
        state <= READY;
        ready <= 1'b1;
      end
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      respValid <= 1'b0;
      respHit <= 1'b0;
      respTarget <= '0;
    end else begin
      respValid <= lookupValid;
      respHit <= lgo;
      respTarget <= lgo ? PC_WIDTH'(make_target(raw_t'(lookupPC), raw_t'(lcont), CONTENT_WIDTH)) : '0;
    end
endmodule
